// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer: FSM states and the
// prioritised per-step action chosen from the decoded control flags.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_e;

    typedef enum logic [2:0] {
        ACT_HALT = 3'd0,
        ACT_RET  = 3'd1,
        ACT_CALL = 3'd2,
        ACT_JUMP = 3'd3,
        ACT_INC  = 3'd4
    } seq_action_e;

    // Priority encoder; cond_taken only matters for a conditional jump.
    function automatic seq_action_e select_action(
        input logic halt_req,
        input logic is_ret,
        input logic is_call,
        input logic is_branch,
        input logic cond_taken
    );
        if (halt_req)                    return ACT_HALT;
        else if (is_ret)                 return ACT_RET;
        else if (is_call)                return ACT_CALL;
        else if (is_branch && cond_taken) return ACT_JUMP;
        else                             return ACT_INC;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. Only the occupancy pointer is reset; entry contents
// are don't-care until written.
module pc_sequencer_ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [$clog2(DEPTH):0]     depth_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    ptr_q;
    logic [DW-1:0]    ptr_d;
    logic [DW-1:0]    top_ptr;
    logic [AW-1:0]    top_idx;

    assign full_o   = (ptr_q == DW'(DEPTH));
    assign empty_o  = (ptr_q == '0);
    assign depth_o  = ptr_q;
    assign top_ptr  = ptr_q - DW'(1);
    assign top_idx  = top_ptr[AW-1:0];
    assign top_o    = mem_q[top_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (push_i && !full_o)
            ptr_d = ptr_q + DW'(1);
        else if (pop_i && !empty_o)
            ptr_d = ptr_q - DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    // Write lands on the push edge, so a pop on the very next step sees it.
    always_ff @(posedge clk) begin
        if (push_i && !full_o)
            mem_q[ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection (increment / jump / call / return) with a RUN-HALT-FAULT
// FSM; HALT and FAULT freeze all state until reset.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_i,
    input  logic                   is_branch_i,
    input  logic                   cond_taken_i,
    input  logic                   is_call_i,
    input  logic                   is_ret_i,
    input  logic                   halt_req_i,
    input  logic [WIDTH-1:0]       target_i,
    output logic [WIDTH-1:0]       pc_o,
    output logic [$clog2(DEPTH):0] depth_o,
    output logic                   halted_o,
    output logic                   fault_o,
    output seq_state_e             dbg_state_o
);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full, stk_empty;
    logic             push, pop;
    seq_action_e      action;

    assign pc_inc = pc_q + STEP_W;
    assign action = select_action(halt_req_i, is_ret_i, is_call_i,
                                  is_branch_i, cond_taken_i);

    pc_sequencer_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .depth_o (depth_o),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (step_i && state_q == ST_RUN) begin
            case (action)
                ACT_HALT: state_d = ST_HALT;
                ACT_RET: begin
                    if (stk_empty) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = stk_top;
                        pop  = 1'b1;
                    end
                end
                ACT_CALL: begin
                    if (stk_full) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = target_i;
                        push = 1'b1;
                    end
                end
                ACT_JUMP: pc_d = target_i;
                default:  pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o        = pc_q;
    assign halted_o    = (state_q == ST_HALT);
    assign fault_o     = (state_q == ST_FAULT);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed PC/depth/flag expectations
// for sequencing, branches, call/return nesting, wrap, halt, fault and reset.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         step = 1'b0;
    logic         is_branch = 1'b0;
    logic         cond_taken = 1'b0;
    logic         is_call = 1'b0;
    logic         is_ret = 1'b0;
    logic         halt_req = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] pc;
    logic [2:0]   depth;
    logic         halted;
    logic         fault;
    seq_state_e   dbg_state;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(W), .STEP(1), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .step_i       (step),
        .is_branch_i  (is_branch),
        .cond_taken_i (cond_taken),
        .is_call_i    (is_call),
        .is_ret_i     (is_ret),
        .halt_req_i   (halt_req),
        .target_i     (target),
        .pc_o         (pc),
        .depth_o      (depth),
        .halted_o     (halted),
        .fault_o      (fault),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] e_pc, input int e_depth,
                              input logic e_halt, input logic e_fault);
        check_eq({tag, ".pc"},     32'(pc),     32'(e_pc));
        check_eq({tag, ".depth"},  32'(depth),  32'(e_depth));
        check_eq({tag, ".halted"}, 32'(halted), 32'(e_halt));
        check_eq({tag, ".fault"},  32'(fault),  32'(e_fault));
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; applies one step, returns at the next posedge+1.
    task automatic drive(input logic br, input logic ct, input logic cl, input logic rt,
                         input logic hl, input logic [W-1:0] tgt);
        step = 1'b1; is_branch = br; cond_taken = ct;
        is_call = cl; is_ret = rt; halt_req = hl; target = tgt;
        @(posedge clk);
        #1;
        step = 1'b0; is_branch = 1'b0; cond_taken = 1'b0;
        is_call = 1'b0; is_ret = 1'b0; halt_req = 1'b0; target = '0;
    endtask

    task automatic do_inc();                      drive(0, 0, 0, 0, 0, '0);  endtask
    task automatic do_jump(input logic [W-1:0] t); drive(1, 1, 0, 0, 0, t);   endtask
    task automatic do_call(input logic [W-1:0] t); drive(0, 0, 1, 0, 0, t);   endtask
    task automatic do_ret();                      drive(0, 0, 0, 1, 0, '0);  endtask

    task automatic reset_dut();
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 rst = 1'b1;
        #1;
        expect_out("reset", 8'h00, 0, 0, 0);
        check_eq("reset.state", 32'(dbg_state), 32'(ST_RUN));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // plain sequencing 1..5
        for (int i = 1; i <= 5; i++) begin
            do_inc();
            expect_out($sformatf("seq%0d", i), W'(i), 0, 0, 0);
        end

        // asynchronous reset mid-run, checked away from any clock edge
        #2 rst = 1'b1;
        #1;
        expect_out("async_rst", 8'h00, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // branches
        do_inc(); do_inc(); do_inc();
        expect_out("pc3", 8'h03, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 8'h40);
        expect_out("br_not_taken", 8'h04, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 8'h40);
        expect_out("br_taken", 8'h40, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 8'h77);
        expect_out("cond_no_branch", 8'h41, 0, 0, 0);

        // nested call / return
        do_jump(8'h10);
        expect_out("jmp10", 8'h10, 0, 0, 0);
        do_call(8'h80);
        expect_out("call80", 8'h80, 1, 0, 0);
        do_call(8'hA0);
        expect_out("callA0", 8'hA0, 2, 0, 0);
        do_ret();
        expect_out("ret1", 8'h81, 1, 0, 0);
        do_ret();
        expect_out("ret2", 8'h11, 0, 0, 0);

        // underflow
        do_ret();
        expect_out("underflow", 8'h11, 0, 0, 1);
        check_eq("underflow.state", 32'(dbg_state), 32'(ST_FAULT));
        do_inc();
        expect_out("fault_frozen_inc", 8'h11, 0, 0, 1);
        do_call(8'h33);
        expect_out("fault_frozen_call", 8'h11, 0, 0, 1);
        reset_dut();
        expect_out("after_rst1", 8'h00, 0, 0, 0);

        // modulo wrap of pc and of pushed return address
        do_jump(8'hFF);
        do_inc();
        expect_out("wrap_inc", 8'h00, 0, 0, 0);
        do_jump(8'hFF);
        do_call(8'h20);
        expect_out("wrap_call", 8'h20, 1, 0, 0);
        do_ret();
        expect_out("wrap_ret", 8'h00, 0, 0, 0);

        // overflow on the fifth nested call
        do_call(8'h10); do_call(8'h20); do_call(8'h30); do_call(8'h40);
        expect_out("stack_full", 8'h40, 4, 0, 0);
        do_call(8'h50);
        expect_out("overflow", 8'h40, 4, 0, 1);
        do_inc();
        expect_out("ovf_frozen_inc", 8'h40, 4, 0, 1);
        do_ret();
        expect_out("ovf_frozen_ret", 8'h40, 4, 0, 1);
        reset_dut();
        expect_out("after_rst2", 8'h00, 0, 0, 0);

        // step=0 ignores toggling controls
        do_jump(8'h22);
        do_call(8'h60);
        expect_out("pre_hold", 8'h60, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step = 1'b0;
            is_branch = i[0]; cond_taken = 1'b1;
            is_call = i[1]; is_ret = ~i[0]; halt_req = i[0] ^ i[1];
            target = 8'h99;
            @(posedge clk);
            #1;
            expect_out($sformatf("hold%0d", i), 8'h60, 1, 0, 0);
        end
        is_branch = 0; cond_taken = 0; is_call = 0; is_ret = 0; halt_req = 0; target = '0;

        // halt wins over everything and is terminal
        drive(1, 1, 1, 1, 1, 8'h99);
        expect_out("halt", 8'h60, 1, 1, 0);
        check_eq("halt.state", 32'(dbg_state), 32'(ST_HALT));
        do_inc();
        expect_out("halt_frozen_inc", 8'h60, 1, 1, 0);
        do_ret();
        expect_out("halt_frozen_ret", 8'h60, 1, 1, 0);
        reset_dut();
        expect_out("after_rst3", 8'h00, 0, 0, 0);

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
